// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared encodings for the fetch/data memory arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_MAX_DATA_BURST = 4;
  localparam int DEF_TIMEOUT        = 255;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_src_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_starve_ctr.sv
// ============================================================================
// arb_starve_ctr : data-over-fetch grant decision with a saturating burst limit
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_BURST = DEF_MAX_DATA_BURST
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     arb_en_i,
  input  logic     if_req_i,
  input  logic     if_elig_i,
  input  logic     dm_elig_i,
  output logic     gnt_o,
  output gnt_src_t gnt_src_o
);

  localparam logic [3:0] C_BURST_MAX = 4'(MAX_DATA_BURST);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       w_starve;

  // A waiting fetch that has already conceded the full burst wins next.
  assign w_starve  = if_elig_i & (cnt_q == C_BURST_MAX);
  assign gnt_o     = arb_en_i & (if_elig_i | dm_elig_i);
  assign gnt_src_o = (dm_elig_i & ~w_starve) ? GNT_DM : GNT_IF;

  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_i || (gnt_o && (gnt_src_o == GNT_IF))) begin
      cnt_d = '0;
    end else if (gnt_o && (cnt_q != C_BURST_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one MIO bus between instruction fetch and data port
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_DATA_BURST = DEF_MAX_DATA_BURST,
  parameter int TIMEOUT        = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              bus_err
);

  if ((MAX_DATA_BURST < 1) || (MAX_DATA_BURST > 15)) begin : g_bad_burst
    $error("mem_port_arbiter: MAX_DATA_BURST must be 1..15");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be 1..255");
  end

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;

  logic              w_gnt;
  gnt_src_t          w_gnt_src;
  logic              w_tmo;
  logic              w_busy;
  logic [DATA_W-1:0] w_rdata;

  assign w_busy = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);

  arb_starve_ctr #(
    .MAX_DATA_BURST (MAX_DATA_BURST)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .arb_en_i  (state_q == ST_IDLE),
    .if_req_i  (if_req),
    .if_elig_i (if_req & ~if_ready_q),
    .dm_elig_i (dm_req & ~dm_ready_q),
    .gnt_o     (w_gnt),
    .gnt_src_o (w_gnt_src)
  );

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_q;
  logic       bus_err_q;

  assign w_tmo   = w_busy & ~mem_ack & (wait_q == C_TMO_LAST);
  assign bus_err = bus_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q    <= w_busy ? (wait_q + 8'd1) : 8'd0;
      bus_err_q <= w_tmo;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign bus_err = 1'b0;
`endif

  // An aborted read returns all-ones so the core never consumes stale data.
  assign w_rdata = mem_ack ? mem_rdata : {DATA_W{1'b1}};

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_gnt) begin
          mem_req_d = 1'b1;
          if (w_gnt_src == GNT_DM) begin
            state_d     = ST_BUSY_D;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            state_d    = ST_BUSY_I;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ack || w_tmo) begin
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
          if (state_q == ST_BUSY_I) begin
            if_ready_d = 1'b1;
            if_rdata_d = w_rdata;
          end else begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = w_rdata;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;

  // Reset forces every output low, the stall included.
  assign stall = ~rst & ((if_req & ~if_ready_q) | (dm_req & ~dm_ready_q));

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .MAX_DATA_BURST (4),
    .TIMEOUT        (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .bus_err   (bus_err)
  );

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0h exp 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    checks++; if ({if_ready, dm_ready, bus_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {if_ready, dm_ready, bus_err}); end
    checks++; if ({if_rdata, dm_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", {if_rdata, dm_rdata}); end
    if_req = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", stall); end
    if_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    if_addr = 32'h0000_0010; if_req = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_req got %0h exp 1", stall); end
    @(negedge clk);
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h10}) begin errors++; $display("FAIL fetch_bus got req=%0h we=%0h addr=%h exp 1 0 00000010", mem_req, mem_we, mem_addr); end
    repeat (2) @(negedge clk);
    checks++; if ({mem_req, if_ready, stall} !== 3'b101) begin errors++; $display("FAIL fetch_wait got %b exp 101", {mem_req, if_ready, stall}); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    @(negedge clk);
    checks++; if ({if_ready, mem_req, stall, bus_err} !== 4'b1000) begin errors++; $display("FAIL fetch_done got %b exp 1000", {if_ready, mem_req, stall, bus_err}); end
    checks++; if (if_rdata !== 32'h2008_0005) begin errors++; $display("FAIL fetch_rdata got %h exp 20080005", if_rdata); end
    mem_ack = 1'b0; mem_rdata = '0; if_req = 1'b0;
    @(negedge clk);
    checks++; if ({if_ready, if_rdata} !== {1'b0, 32'h2008_0005}) begin errors++; $display("FAIL fetch_hold got rdy=%0h data=%h exp 0 20080005", if_ready, if_rdata); end
  endtask

  task automatic test_data_priority();
    if_addr = 32'h40; if_req = 1'b1;
    dm_addr = 32'h100; dm_we = 1'b0; dm_req = 1'b1;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin errors++; $display("FAIL prio_first got req=%0h we=%0h addr=%h exp 1 0 00000100", mem_req, mem_we, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    checks++; if ({dm_ready, if_ready, stall} !== 3'b101) begin errors++; $display("FAIL prio_dm_done got %b exp 101", {dm_ready, if_ready, stall}); end
    checks++; if (dm_rdata !== 32'h1111_2222) begin errors++; $display("FAIL prio_dm_rdata got %h exp 11112222", dm_rdata); end
    mem_ack = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    checks++; if ({mem_req, dm_ready} !== 2'b00) begin errors++; $display("FAIL prio_arb_cycle got %b exp 00", {mem_req, dm_ready}); end
    @(negedge clk);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL prio_fetch got req=%0h addr=%h exp 1 00000040", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    @(negedge clk);
    checks++; if ({if_ready, dm_ready, if_rdata} !== {2'b10, 32'h3333_4444}) begin errors++; $display("FAIL prio_if_done got %b data=%h exp 10 33334444", {if_ready, dm_ready}, if_rdata); end
    mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    checks++; if ({if_ready, dm_ready} !== 2'b00) begin errors++; $display("FAIL prio_single_pulse got %b exp 00", {if_ready, dm_ready}); end
  endtask

  task automatic test_write();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h200, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_bus got req=%0h we=%0h addr=%h wd=%h exp 1 1 00000200 deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    checks++; if ({mem_req, mem_we, mem_wdata} !== {2'b11, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_stable got req=%0h we=%0h wd=%h exp 1 1 deadbeef", mem_req, mem_we, mem_wdata); end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++; if ({dm_ready, dm_rdata} !== {1'b1, 32'h1111_2222}) begin errors++; $display("FAIL wr_done got rdy=%0h rdata=%h exp 1 11112222", dm_ready, dm_rdata); end
    mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [6:0] seq;
    int ng, nd, ni;
    seq = '0; ng = 0; nd = 0; ni = 0;
    if_addr = 32'h80; if_req = 1'b1;
    dm_addr = 32'h300; dm_we = 1'b0; dm_req = 1'b1;
    for (int cyc = 0; (cyc < 200) && (nd < 6); cyc++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        seq = {seq[5:0], (mem_addr != 32'h80)};
        ng++;
        mem_ack = 1'b1;
        mem_rdata = mem_addr ^ 32'hA5A5_0000;
      end
      if (dm_ready) begin
        checks++; if (dm_rdata !== (dm_addr ^ 32'hA5A5_0000)) begin errors++; $display("FAIL b2b_rdata got %h exp %h", dm_rdata, dm_addr ^ 32'hA5A5_0000); end
        nd++;
        if (nd == 6) begin
          dm_req = 1'b0; if_req = 1'b0;
        end else begin
          dm_addr = dm_addr + 32'd4;
        end
      end
      if (if_ready) ni++;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (nd !== 6) begin errors++; $display("FAIL b2b_timeout got %0d data completions exp 6", nd); end
    checks++; if (seq !== 7'b1111011) begin errors++; $display("FAIL b2b_order got %b exp 1111011 (1=D)", seq); end
    checks++; if ({ng, ni} !== {32'd7, 32'd1}) begin errors++; $display("FAIL b2b_counts got grants=%0d fetches=%0d exp 7 1", ng, ni); end
  endtask

  task automatic test_reset_mid();
    mem_ack = 1'b1;
    @(negedge clk);
    checks++; if ({mem_req, if_ready, dm_ready} !== 3'b000) begin errors++; $display("FAIL stray_ack got %b exp 000", {mem_req, if_ready, dm_ready}); end
    mem_ack = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_busy got %0h exp 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_req, stall, dm_ready} !== 3'b000) begin errors++; $display("FAIL rmid_async got %b exp 000", {mem_req, stall, dm_ready}); end
    @(negedge clk);
    dm_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_idle got %0h exp 0", mem_req); end
    dm_req = 1'b1; dm_addr = 32'h404;
    @(negedge clk);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h404}) begin errors++; $display("FAIL rmid_regrant got req=%0h addr=%h exp 1 00000404", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    checks++; if ({dm_ready, dm_rdata} !== {1'b1, 32'h0BAD_F00D}) begin errors++; $display("FAIL rmid_done got rdy=%0h rdata=%h exp 1 0badf00d", dm_ready, dm_rdata); end
    mem_ack = 1'b0; dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    @(negedge clk);
`ifdef MEM_TIMEOUT_EN
    while (mem_req && (n < 40)) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL tmo_busy_cycles got %0d exp 8", n); end
    checks++; if ({bus_err, dm_ready, mem_req} !== 3'b110) begin errors++; $display("FAIL tmo_pulse got %b exp 110", {bus_err, dm_ready, mem_req}); end
    checks++; if (dm_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmo_rdata got %h exp ffffffff", dm_rdata); end
    dm_req = 1'b0;
    @(negedge clk);
    checks++; if ({bus_err, dm_ready} !== 2'b00) begin errors++; $display("FAIL tmo_clear got %b exp 00", {bus_err, dm_ready}); end
`else
    while (mem_req && (n < 20)) begin
      n++;
      @(negedge clk);
    end
    checks++; if ({n, dm_ready, bus_err} !== {32'd20, 2'b00}) begin errors++; $display("FAIL notmo_wait got n=%0d rdy=%0h err=%0h exp 20 0 0", n, dm_ready, bus_err); end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if ({dm_ready, bus_err, dm_rdata} !== {2'b10, 32'h1234_5678}) begin errors++; $display("FAIL notmo_done got rdy=%0h err=%0h rdata=%h exp 1 0 12345678", dm_ready, bus_err, dm_rdata); end
    mem_ack = 1'b0; dm_req = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data_priority();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port memory bus (MIO) between the pipelined CPU's instruction-fetch port and its data (MEM-stage) port. It arbitrates, sequences each transaction through the variable-latency memory handshake, returns read data, and generates the pipeline stall. Sits between the CPU core and the memory/IO bus.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch waits (range 1..15)
TIMEOUT, 255, cycles to wait for mem_ack before aborting (MEM_TIMEOUT_EN only, range 1..255)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address, stable while if_req
if_rdata  out  DATA_W  fetched instruction, valid with if_ready
if_ready  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request, held until dm_ready
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  read data, valid with dm_ready
dm_ready  out  1  one-cycle data completion pulse
mem_req  out  1  bus request (CPU_MIO)
mem_we  out  1  bus write enable
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_rdata  in  DATA_W  bus read data, valid with mem_ack
mem_ack  in  1  bus completion (MIO_ready)
stall  out  1  freeze pipeline
bus_err  out  1  one-cycle timeout pulse (MEM_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset: FSM=IDLE; all outputs 0; burst counter 0. Async reset mid-transaction drops mem_req immediately; the outstanding transaction is abandoned.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: arbitrate among eligible requests (requester not pulsing ready this cycle). Priority: data over fetch, except when if_req is pending and burst counter == MAX_DATA_BURST -> grant fetch. On grant, register mem_addr/mem_we/mem_wdata at the edge, mem_req=1 from next cycle; go BUSY_D or BUSY_I.
- Burst counter: +1 per data grant while if_req high (saturates at MAX_DATA_BURST); cleared on any fetch grant or when if_req low.
- BUSY_x: mem_req/mem_* held stable. At the edge sampling mem_ack=1: latch mem_rdata into if_rdata or dm_rdata (writes leave dm_rdata unchanged), pulse the matching ready for exactly the next cycle, drop mem_req, go DONE.
- DONE: one cycle; ready pulse visible; then IDLE. The requester must deassert or change req at the same edge.
- Minimum latency: req seen in cycle 0 -> mem_req cycle 1 -> ack in cycle 1 -> ready in cycle 2 -> next grant arbitrated in cycle 3.
- mem_ack while not BUSY: ignored.
- if_rdata/dm_rdata hold their last value between transactions.
- stall = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.
- Simultaneous if_req & dm_req in IDLE: data wins unless the starvation rule applies.

Optional Feature:
MEM_TIMEOUT_EN: an 8-bit wait counter runs in BUSY_x. When it reaches TIMEOUT without ack: drop mem_req, pulse bus_err together with the requester's ready, return read data as all-ones, go DONE. Without the macro: no counter; wait indefinitely; bus_err constant 0.

Decomposition:
- Shared package: FSM state encoding (IDLE/BUSY_I/BUSY_D/DONE, 2-bit), grant-source enum (GNT_IF, GNT_DM), default widths.
- One natural sub-module: arb_starve_ctr (saturating burst counter plus grant decision), instantiated once.

Test Plan:
- if_req only, addr 0x0000_0010; mem_ack 3 cycles after mem_req -> mem_addr=0x10, mem_we=0; if_ready one cycle with if_rdata=mem_rdata (0x2008_0005); stall high until if_ready.
- if_req and dm_req (read 0x100) together -> data granted first; fetch granted in the cycle after DONE; each ready pulses exactly once.
- dm_req write, addr 0x200, wdata 0xDEAD_BEEF -> mem_we=1 and mem_wdata stable until ack; dm_rdata unchanged.
- dm_req re-asserted back-to-back 6 times with if_req held, MAX_DATA_BURST=4 -> grant order D,D,D,D,I,D,D.
- rst asserted in BUSY_D -> mem_req, stall, and ready low in the same cycle; FSM IDLE; next request served normally.
- MEM_TIMEOUT_EN, TIMEOUT=8, mem_ack never arrives -> after 8 BUSY cycles: bus_err and dm_ready pulse together, dm_rdata=0xFFFF_FFFF.
